// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: merges ALU results and load results
// onto one registered write port, queueing loads behind ALU writes.
// Optional macro WB_LOAD_BYPASS_EN lets a load on an idle port skip the queue.
module reg_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_AluWrEn,
  input  logic [ADDR_WIDTH-1:0]    i_AluWrAddr,
  input  logic [DATA_WIDTH-1:0]    i_AluWrData,
  input  logic                     i_LdValid,
  input  logic [ADDR_WIDTH-1:0]    i_LdAddr,
  input  logic [DATA_WIDTH-1:0]    i_LdData,
  output logic                     o_LdReady,
  output logic                     o_RegWrEn,
  output logic [ADDR_WIDTH-1:0]    o_RegWrAddr,
  output logic [DATA_WIDTH-1:0]    o_RegWrData,
  output logic [2**ADDR_WIDTH-1:0] o_PendMask
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_live;
  logic [FIFO_DEPTH-1:0] live_nxt;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic alu_win;
  logic ld_acc;
  logic ld_zero;
  logic ld_squash;
  logic bypass;
  logic push;
  logic pop;

  assign o_LdReady = (count < CNT_W'(FIFO_DEPTH));
  assign alu_win   = i_AluWrEn && (i_AluWrAddr != '0);
  assign ld_acc    = i_LdValid && o_LdReady;
  assign ld_zero   = (i_LdAddr == '0);
  // A same-cycle ALU write to the same register is younger, so the load is dropped.
  assign ld_squash = alu_win && (i_LdAddr == i_AluWrAddr);
  assign pop       = !alu_win && (count != '0);

`ifdef WB_LOAD_BYPASS_EN
  assign bypass = ld_acc && (count == '0) && !alu_win && !ld_zero;
`else
  assign bypass = 1'b0;
`endif

  assign push = ld_acc && !ld_zero && !ld_squash && !bypass;

  // Next liveness: squash matching entries, retire the popped head, arm the pushed tail.
  always_comb begin
    live_nxt = q_live;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_win && (q_addr[i] == i_AluWrAddr)) live_nxt[i] = 1'b0;
    end
    if (pop)  live_nxt[head] = 1'b0;
    if (push) live_nxt[tail] = 1'b1;
  end

  // Queue control state: pointers, occupancy and live bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      q_live <= live_nxt;
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // Queue payload storage; contents are meaningless unless the live bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= i_LdAddr;
      q_data[tail] <= i_LdData;
    end
  end

  // Registered write port: ALU first, then queue head, then direct load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_RegWrEn   <= 1'b0;
      o_RegWrAddr <= '0;
      o_RegWrData <= '0;
    end else if (alu_win) begin
      o_RegWrEn   <= 1'b1;
      o_RegWrAddr <= i_AluWrAddr;
      o_RegWrData <= i_AluWrData;
    end else if (pop) begin
      o_RegWrEn <= q_live[head];
      if (q_live[head]) begin
        o_RegWrAddr <= q_addr[head];
        o_RegWrData <= q_data[head];
      end
    end else if (bypass) begin
      o_RegWrEn   <= 1'b1;
      o_RegWrAddr <= i_LdAddr;
      o_RegWrData <= i_LdData;
    end else begin
      o_RegWrEn <= 1'b0;
    end
  end

  // Pending mask built from live queue entries; register 0 never reported.
  always_comb begin
    o_PendMask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_live[i]) o_PendMask[q_addr[i]] = 1'b1;
    end
    o_PendMask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: stimulus queues expected writes,
// a negedge monitor checks every asserted write against the queue.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_AluWrEn = 1'b0;
  logic [4:0]  i_AluWrAddr = '0;
  logic [31:0] i_AluWrData = '0;
  logic        i_LdValid = 1'b0;
  logic [4:0]  i_LdAddr = '0;
  logic [31:0] i_LdData = '0;
  logic        o_LdReady;
  logic        o_RegWrEn;
  logic [4:0]  o_RegWrAddr;
  logic [31:0] o_RegWrData;
  logic [31:0] o_PendMask;

`ifdef WB_LOAD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  reg_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .i_AluWrEn(i_AluWrEn), .i_AluWrAddr(i_AluWrAddr), .i_AluWrData(i_AluWrData),
    .i_LdValid(i_LdValid), .i_LdAddr(i_LdAddr), .i_LdData(i_LdData),
    .o_LdReady(o_LdReady), .o_RegWrEn(o_RegWrEn), .o_RegWrAddr(o_RegWrAddr),
    .o_RegWrData(o_RegWrData), .o_PendMask(o_PendMask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_AluWrEn = 1'b0; i_AluWrAddr = '0; i_AluWrData = '0;
    i_LdValid = 1'b0; i_LdAddr = '0; i_LdData = '0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    i_AluWrEn = 1'b1; i_AluWrAddr = a; i_AluWrData = d;
  endtask

  task automatic ld(input logic [4:0] a, input logic [31:0] d);
    i_LdValid = 1'b1; i_LdAddr = a; i_LdData = d;
  endtask

  // Monitor: every write outside reset must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && o_RegWrEn) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got x%0d=%0h expected none", o_RegWrAddr, o_RegWrData);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(o_RegWrAddr), 64'(w.a));
        chk("wr_data", 64'(o_RegWrData), 64'(w.d));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    #2;
    chk("rst_en", 64'(o_RegWrEn), 64'd0);
    chk("rst_addr", 64'(o_RegWrAddr), 64'd0);
    chk("rst_data", 64'(o_RegWrData), 64'd0);
    chk("rst_pend", 64'(o_PendMask), 64'd0);
    chk("rst_ready", 64'(o_LdReady), 64'd1);
    step();
    step();
    reset = 1'b0;
    step();

    // ALU write, one-cycle latency
    alu(5'd5, 32'h11111111); expect_wr(5'd5, 32'h11111111);
    step(); idle();
    chk("alu_en", 64'(o_RegWrEn), 64'd1);
    chk("alu_pend", 64'(o_PendMask), 64'd0);

    // ALU and load together: load queued behind
    alu(5'd3, 32'hA); ld(5'd4, 32'hB);
    expect_wr(5'd3, 32'hA); expect_wr(5'd4, 32'hB);
    step(); idle();
    chk("pend_x4", 64'(o_PendMask), 64'h10);
    step();
    chk("pend_x4_clr", 64'(o_PendMask), 64'd0);
    chk("x4_en", 64'(o_RegWrEn), 64'd1);

    // Fill queue behind continuous ALU traffic
    alu(5'd1, 32'h1); ld(5'd6, 32'h6); expect_wr(5'd1, 32'h1);
    step();
    alu(5'd2, 32'h2); ld(5'd7, 32'h7); expect_wr(5'd2, 32'h2);
    step();
    chk("full_ready", 64'(o_LdReady), 64'd0);
    alu(5'd1, 32'h3); ld(5'd10, 32'h10); expect_wr(5'd1, 32'h3);
    step(); idle();
    chk("held_ready", 64'(o_LdReady), 64'd0);
    chk("full_pend", 64'(o_PendMask), 64'hC0);
    expect_wr(5'd6, 32'h6); expect_wr(5'd7, 32'h7);
    step();
    chk("drain1_ready", 64'(o_LdReady), 64'd1);
    chk("drain1_pend", 64'(o_PendMask), 64'h80);
    step();
    chk("drain2_pend", 64'(o_PendMask), 64'd0);
    step();
    chk("drained_en", 64'(o_RegWrEn), 64'd0);

    // Squash a queued load
    alu(5'd1, 32'h1); ld(5'd8, 32'hDEAD); expect_wr(5'd1, 32'h1);
    step(); idle();
    chk("sq_pend_set", 64'(o_PendMask), 64'h100);
    alu(5'd8, 32'hBEEF); expect_wr(5'd8, 32'hBEEF);
    step(); idle();
    chk("sq_pend_clr", 64'(o_PendMask), 64'd0);
    step();
    chk("dead_pop_en", 64'(o_RegWrEn), 64'd0);
    chk("dead_pop_ready", 64'(o_LdReady), 64'd1);

    // Lone load latency
    ld(5'd9, 32'h99); expect_wr(5'd9, 32'h99);
    step(); idle();
    chk("ld_lat1_en", 64'(o_RegWrEn), 64'(BYP));
    step();
    chk("ld_lat2_en", 64'(o_RegWrEn), 64'(!BYP));
    step();

    // Loads to x0 discarded; ALU x0 ignored but queue proceeds
    ld(5'd0, 32'h55);
    step(); idle();
    chk("ld_x0_en", 64'(o_RegWrEn), 64'd0);
    chk("ld_x0_pend", 64'(o_PendMask), 64'd0);
    alu(5'd0, 32'h66); ld(5'd11, 32'h11B); expect_wr(5'd11, 32'h11B);
    step(); idle();
    step();
    step();

    // Reset mid-operation with two queued loads
    alu(5'd1, 32'h5); ld(5'd12, 32'hC); expect_wr(5'd1, 32'h5);
    step();
    alu(5'd2, 32'h6); ld(5'd13, 32'hD); expect_wr(5'd2, 32'h6);
    step(); idle();
    chk("pre_rst_pend", 64'(o_PendMask), 64'h3000);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_en", 64'(o_RegWrEn), 64'd0);
    chk("mid_rst_addr", 64'(o_RegWrAddr), 64'd0);
    chk("mid_rst_data", 64'(o_RegWrData), 64'd0);
    chk("mid_rst_pend", 64'(o_PendMask), 64'd0);
    chk("mid_rst_ready", 64'(o_LdReady), 64'd1);
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    step();
    chk("post_rst_en", 64'(o_RegWrEn), 64'd0);
    alu(5'd0, 32'h77);
    step(); idle();
    chk("alu_x0_en", 64'(o_RegWrEn), 64'd0);
    step();
    @(negedge clk);
    #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 32, write data width.
- FIFO_DEPTH, 2, load-result queue entries (power of two, >=2).

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, all state on rising edge.
- reset, in, 1, asynchronous active-high reset.
- i_AluWrEn, in, 1, ALU result write request (always accepted).
- i_AluWrAddr, in, ADDR_WIDTH, ALU destination register.
- i_AluWrData, in, DATA_WIDTH, ALU result.
- i_LdValid, in, 1, load result valid.
- i_LdAddr, in, ADDR_WIDTH, load destination register.
- i_LdData, in, DATA_WIDTH, load data.
- o_LdReady, out, 1, load result accepted this cycle when high with i_LdValid.
- o_RegWrEn, out, 1, register file write enable.
- o_RegWrAddr, out, ADDR_WIDTH, register file write index.
- o_RegWrData, out, DATA_WIDTH, register file write data.
- o_PendMask, out, 2**ADDR_WIDTH, bit n set while a live queued load targets register n.

REQ-003 One clock; reset is asynchronous and active-high, ports named clk and reset.

Function
REQ-004 o_RegWrEn/Addr/Data SHALL be registered outputs, updated every rising edge.
REQ-005 Output select priority each cycle: (1) ALU request with i_AluWrAddr!=0; (2) FIFO head; (3) direct load (REQ-014 only); (4) none -> o_RegWrEn=0, Addr/Data hold.
REQ-006 ALU requests SHALL never stall; ALU-to-register-file latency is exactly 1 cycle.
REQ-007 o_LdReady = (FIFO occupancy < FIFO_DEPTH), from registered count only; no combinational path from i_LdValid or i_AluWrEn.
REQ-008 Accepted load (valid & ready) not taken directly SHALL be pushed at FIFO tail; FIFO order preserved.
REQ-009 Pop of head SHALL occur when ALU does not win that cycle; a live head drives o_RegWrEn=1, a dead head pops with o_RegWrEn=0.
REQ-010 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-011 Squash: an ALU request to register A != 0 SHALL mark dead every queued entry with address A and SHALL drop a same-cycle accepted load to A (ALU write is program-order younger).
REQ-012 Writes to register 0 from either source SHALL never assert o_RegWrEn; loads to register 0 are accepted and discarded (not queued).
REQ-013 o_PendMask SHALL reflect live FIFO entries after the current edge; bit 0 always 0.

Reset
REQ-015 While reset high: o_RegWrEn=0, o_RegWrAddr=0, o_RegWrData=0, FIFO empty, all entries dead, o_PendMask=0, o_LdReady=1 (after first edge-free evaluation).
REQ-016 Reset asserted mid-operation SHALL discard all queued loads with no write issued; first write possible on the first rising edge after reset deassertion.

Configuration
REQ-014 Macro WB_LOAD_BYPASS_EN:
- Defined: load accepted with FIFO empty and no ALU request (or ALU to x0) goes straight to output registers, 1-cycle latency, not queued.
- Undefined: every accepted load is queued; minimum load latency 2 cycles; priority (3) of REQ-005 absent.

Verification
REQ-017 ALU x5=0x11111111 in cycle 0 -> next cycle o_RegWrEn=1, Addr=5, Data=0x11111111; o_PendMask=0.
REQ-018 Same cycle ALU x3=0xA, load x4=0xB -> cycle+1 write x3=0xA, PendMask bit4=1; cycle+2 write x4=0xB, PendMask=0.
REQ-019 Loads x6, x7 queued behind continuous ALU writes (FIFO_DEPTH=2) -> o_LdReady=0 with third load held; after ALU stops, writes x6 then x7 in order, then ready=1.
REQ-020 Load x8=0xDEAD queued, then ALU x8=0xBEEF -> write x8=0xBEEF only; dead entry pops with o_RegWrEn=0; PendMask bit8 clears at the squash edge.
REQ-021 Load x9 alone on idle bus -> with WB_LOAD_BYPASS_EN write x9 after 1 cycle; without, after 2 cycles.
REQ-022 Reset asserted with 2 queued loads -> outputs 0 immediately, no write of either load after deassertion; ALU x0 request -> o_RegWrEn stays 0.
